// File: rtl/pulp_clock_div_pkg.sv
// Shared types and constants for the ICG enable divider.
// The state enum and the zero-divider mapping are used by the top-level FSM.
package pulp_clock_div_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } clk_div_state_e;

  // A programmed divider of zero behaves like a divide-by-one.
  localparam int unsigned DIV_ZERO_MAP = 1;

endpackage

// File: rtl/pulp_clock_div_en_if.sv
// Request/status bundle between a controller and the ICG enable divider.
// The master drives requests; the slave (the divider) returns status.
interface pulp_clock_div_en_if #(
  parameter int unsigned DIV_WIDTH = 8
) ();

  logic                 test_mode_i;
  logic                 enable_i;
  logic [DIV_WIDTH-1:0] div_i;
  logic                 div_valid_i;
  logic                 div_ready_o;
  logic                 en_o;
  logic                 running_o;

  modport master (
    output test_mode_i, enable_i, div_i, div_valid_i,
    input  div_ready_o, en_o, running_o
  );

  modport slave (
    input  test_mode_i, enable_i, div_i, div_valid_i,
    output div_ready_o, en_o, running_o
  );

endinterface

// File: rtl/pulp_clock_div_counter.sv
// Wrap-around period counter: counts 0..limit_i, flags the last count,
// and can be cleared to restart a period.
module pulp_clock_div_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             term_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign term_o = (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = term_o ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pulp_clock_div_en.sv
// Enable generator for an integrated clock gate: one en_o pulse every DIV
// cycles, with boundary-aligned start/stop and divider updates.
module pulp_clock_div_en
  import pulp_clock_div_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned RESET_DIV = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  pulp_clock_div_en_if.slave bus
);

  clk_div_state_e       state_q;
  clk_div_state_e       state_d;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_d;
  logic                 running_q;
  logic                 running_d;

  logic [DIV_WIDTH-1:0] div_eff;
  logic [DIV_WIDTH-1:0] limit;
  logic                 term;
  logic                 div_ready;
  logic                 xfer;
  logic                 cnt_clr;
  logic                 cnt_en;

  assign div_eff   = (div_q == '0) ? DIV_WIDTH'(DIV_ZERO_MAP) : div_q;
  assign limit     = div_eff - DIV_WIDTH'(1);
  assign div_ready = (state_q == STOP) | term;
  assign xfer      = bus.div_valid_i & div_ready;

  // A transfer restarts the period so the counter never exceeds the new limit.
  assign cnt_clr = (state_q == STOP) | xfer;
  assign cnt_en  = (state_q != STOP);

  pulp_clock_div_counter #(
    .WIDTH (DIV_WIDTH)
  ) u_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .limit_i (limit),
    .term_o  (term)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STOP: begin
        if (bus.enable_i) state_d = RUN;
      end
      RUN: begin
        if (!bus.enable_i) state_d = term ? STOP : DRAIN;
      end
      DRAIN: begin
        // Re-enable keeps the current phase; otherwise finish the period.
        if (bus.enable_i) begin
          state_d = RUN;
        end else if (term) begin
          state_d = STOP;
        end
      end
      default: state_d = STOP;
    endcase
  end

  assign div_d     = xfer ? bus.div_i : div_q;
  assign running_d = (state_d != STOP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= STOP;
      div_q     <= DIV_WIDTH'(RESET_DIV);
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      running_q <= running_d;
    end
  end

  // en_o depends only on flops and the DFT override, never on request inputs.
  assign bus.en_o        = bus.test_mode_i | ((state_q != STOP) & term);
  assign bus.div_ready_o = div_ready;
  assign bus.running_o   = running_q;

endmodule
